post_norm_round: RTL

//   Back end of the IEEE754 single-precision adder; the inverse of the pre-normalisation stage.

---
 rtl/post_norm_round.sv | 120 ++++++++++++
 1 files changed

// File: rtl/post_norm_round.sv
// rtl/post_norm_round.sv - IEEE754 single-precision adder back end: normalise, round to nearest-even, pack
module post_norm_round #(
  parameter int EW = 8,
  parameter int MW = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [7:0]  in_e,
  input  logic [28:0] in_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_f,
  output logic        out_of,
  output logic        out_uf
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] NORM  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Internal exponent carries one extra bit so a carry past the all-ones
  // exponent is still visible to the overflow test.
  localparam logic [EW:0] E_ONE = (EW+1)'(1);
  localparam logic [EW:0] E_MAX = {1'b0, {EW{1'b1}}};

  logic [1:0]    state;
  logic          s;
  logic [EW:0]   e;
  logic [MW-1:0] m;

  // Rounding datapath: only the bits from the LSB of the fraction upwards
  // take part in the increment; guard/round/sticky only decide it.
  logic          inc;
  logic [MW-5:0] sum_hi;
  logic          rnd_carry;
  logic [MW-7:0] rnd_frac;
  logic [EW:0]   rnd_e;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Nearest-even increment decision and renormalisation after a rounding carry.
  always_comb begin
    inc       = m[3] & ((|m[2:0]) | m[4]);
    sum_hi    = m[MW-1:4] + (MW-4)'(inc);
    rnd_carry = sum_hi[MW-5];
    rnd_frac  = rnd_carry ? sum_hi[MW-6:1] : sum_hi[MW-7:0];
    rnd_e     = rnd_carry ? (e + E_ONE) : e;
  end

  // Control FSM together with the mantissa/exponent working registers and result latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s      <= 1'b0;
      e      <= '0;
      m      <= '0;
      out_f  <= '0;
      out_of <= 1'b0;
      out_uf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s      <= in_s;
            e      <= {1'b0, in_e};
            m      <= in_m;
            out_f  <= '0;
            out_of <= 1'b0;
            out_uf <= 1'b0;
            state  <= NORM;
          end
        end
        NORM: begin
          if (m == '0) begin
            // Exact cancellation always yields +0.
            out_f <= '0;
            state <= DONE;
          end else if (m[MW-1]) begin
            // Carry out of the add: shift right, keeping the lost bit as sticky.
            m <= {1'b0, m[MW-1:2], m[1] | m[0]};
            e <= e + E_ONE;
          end else if (!m[MW-2]) begin
            if (e > E_ONE) begin
              m <= m << 1;
              e <= e - E_ONE;
            end else begin
              // No exponent range left to normalise into: flush to signed zero.
              out_f  <= {s, 31'h0};
              out_uf <= 1'b1;
              state  <= DONE;
            end
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          if (rnd_e >= E_MAX) begin
            out_f  <= {s, {EW{1'b1}}, {(MW-6){1'b0}}};
            out_of <= 1'b1;
          end else begin
            out_f <= {s, rnd_e[EW-1:0], rnd_frac};
          end
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
